// File: rtl/newsstand_pkg.sv
// Shared types for the newspaper vending path: coin codes, acceptor FSM states
// and default pulse-width thresholds used by the coin acceptor.
package newsstand_pkg;

    typedef enum logic [1:0] {
        NOCOIN = 2'b00,
        NICKEL = 2'b01,
        DIME   = 2'b10
    } coin_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MEASURE = 2'b01,
        JAM     = 2'b10
    } acceptor_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_NICKEL_MIN  = 4;
    localparam int DEF_NICKEL_MAX  = 7;
    localparam int DEF_DIME_MIN    = 10;
    localparam int DEF_DIME_MAX    = 15;
    localparam int DEF_JAM_LIMIT   = 32;

    // Maps a measured high-time to a coin; NOCOIN means the pulse is unrecognised.
    function automatic coin_t classify_width(input int w, input int nmin, input int nmax,
                                             input int dmin, input int dmax);
        coin_t c;
        c = NOCOIN;
        if (w >= nmin && w <= nmax) begin
            c = NICKEL;
        end else if (w >= dmin && w <= dmax) begin
            c = DIME;
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous sensor bit.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin chute front end: measures synchronized sensor pulses, classifies them as
// nickel/dime/invalid, buffers one coin while vending, and flags jams.
module coin_acceptor
    import newsstand_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int NICKEL_MIN  = DEF_NICKEL_MIN,
    parameter int NICKEL_MAX  = DEF_NICKEL_MAX,
    parameter int DIME_MIN    = DEF_DIME_MIN,
    parameter int DIME_MAX    = DEF_DIME_MAX,
    parameter int JAM_LIMIT   = DEF_JAM_LIMIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       coin_sense_i,
    input  logic       vend_busy_i,
    output logic [1:0] coin_o,
    output logic       reject_o,
    output logic       jam_o
);

    localparam int CW = $clog2(JAM_LIMIT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(JAM_LIMIT - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("coin_acceptor: SYNC_STAGES must be at least 2");
    end
    if (!(NICKEL_MIN <= NICKEL_MAX && NICKEL_MAX < DIME_MIN &&
          DIME_MIN <= DIME_MAX && DIME_MAX < JAM_LIMIT)) begin : g_bad_widths
        $error("coin_acceptor: pulse-width thresholds are not ordered");
    end

    logic s;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (coin_sense_i),
        .q_o  (s)
    );

    acceptor_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    coin_t           slot_q, slot_d;
    coin_t           coin_q, coin_d;
    logic            reject_q, reject_d;
    logic            jam_q, jam_d;
    logic            cls_done;
    coin_t           cls;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            slot_q   <= NOCOIN;
            coin_q   <= NOCOIN;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            jam_q    <= jam_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        coin_d   = NOCOIN;
        reject_d = 1'b0;
        cls_done = 1'b0;
        cls      = NOCOIN;

        // A held coin leaves as soon as the vending stage is idle.
        if (slot_q != NOCOIN && !vend_busy_i) begin
            coin_d = slot_q;
            slot_d = NOCOIN;
        end

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = JAM;
                    end
                end else begin
                    state_d  = IDLE;
                    cls_done = 1'b1;
                end
            end
            JAM: begin
                if (!s) begin
                    state_d  = IDLE;
                    reject_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Overflow is judged against the slot as it stood before this edge.
        if (cls_done) begin
            cls = classify_width(int'(cnt_q), NICKEL_MIN, NICKEL_MAX, DIME_MIN, DIME_MAX);
            if (cls == NOCOIN || slot_q != NOCOIN) begin
                reject_d = 1'b1;
            end else if (vend_busy_i) begin
                slot_d = cls;
            end else begin
                coin_d = cls;
            end
        end

        jam_d = (state_d == JAM);
    end

    assign coin_o   = coin_q;
    assign reject_o = reject_q;
    assign jam_o    = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected coin/reject events are queued as
// pulses are driven and matched against DUT output pulses.
module tb_coin_acceptor;

    logic       clk;
    logic       rst;
    logic       coin_sense;
    logic       vend_busy;
    logic [1:0] coin;
    logic       reject;
    logic       jam;

    localparam int EV_NICKEL = 1;
    localparam int EV_DIME   = 2;
    localparam int EV_REJECT = 3;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    coin_acceptor dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .coin_sense_i(coin_sense),
        .vend_busy_i (vend_busy),
        .coin_o      (coin),
        .reject_o    (reject),
        .jam_o       (jam)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input int got);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, got, 0);
        end else begin
            check_eq(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        coin_sense = 1'b1;
        tick(hi);
        coin_sense = 1'b0;
        tick(lo);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (coin != 2'b00) begin
                $display("event: coin=%0d at %0t", coin, $time);
                sb_pop("coin", int'(coin));
            end
            if (reject) begin
                $display("event: reject at %0t", $time);
                sb_pop("reject", EV_REJECT);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        coin_sense = 1'b0;
        vend_busy  = 1'b0;
        tick(3);
        @(negedge clk);
        check_eq("reset_outs", int'({coin, reject, jam}), 0);
        tick(1);
        rst = 1'b0;
        tick(3);

        // Nickel, with exact latency from raw fall.
        exp_q.push_back(EV_NICKEL);
        coin_sense = 1'b1;
        tick(5);
        coin_sense = 1'b0;
        tick(2);
        @(negedge clk);
        check_eq("nickel_early", int'(coin), 0);
        tick(1);
        @(negedge clk);
        check_eq("nickel_latency", int'(coin), EV_NICKEL);
        check_eq("nickel_no_reject", int'(reject), 0);
        tick(1);
        @(negedge clk);
        check_eq("nickel_once", int'(coin), 0);
        tick(6);

        // Dime, gap width, too short.
        exp_q.push_back(EV_DIME);
        pulse(12, 8);
        exp_q.push_back(EV_REJECT);
        pulse(8, 8);
        exp_q.push_back(EV_REJECT);
        pulse(2, 8);

        // Back-to-back nickels with a single low cycle between them.
        exp_q.push_back(EV_NICKEL);
        exp_q.push_back(EV_NICKEL);
        pulse(5, 1);
        pulse(6, 8);

        // Dime held while vending.
        vend_busy = 1'b1;
        exp_q.push_back(EV_DIME);
        pulse(12, 6);
        @(negedge clk);
        check_eq("held_quiet0", int'(coin), 0);
        tick(1);
        @(negedge clk);
        check_eq("held_quiet1", int'(coin), 0);
        tick(1);
        vend_busy = 1'b0;
        tick(1);
        @(negedge clk);
        check_eq("held_emit", int'(coin), EV_DIME);
        tick(1);
        @(negedge clk);
        check_eq("held_once", int'(coin), 0);
        tick(4);

        // Second nickel arrives while the first is still held.
        vend_busy = 1'b1;
        exp_q.push_back(EV_REJECT);
        exp_q.push_back(EV_NICKEL);
        pulse(5, 6);
        pulse(5, 6);
        tick(2);
        vend_busy = 1'b0;
        tick(6);

        // Jammed chute.
        exp_q.push_back(EV_REJECT);
        coin_sense = 1'b1;
        tick(20);
        @(negedge clk);
        check_eq("jam_not_yet", int'(jam), 0);
        tick(18);
        @(negedge clk);
        check_eq("jam_high", int'(jam), 1);
        tick(2);
        coin_sense = 1'b0;
        tick(6);
        @(negedge clk);
        check_eq("jam_cleared", int'(jam), 0);
        tick(4);

        // Reset in the middle of a dime pulse, released while still high.
        exp_q.push_back(EV_REJECT);
        coin_sense = 1'b1;
        tick(3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outs", int'({coin, reject, jam}), 0);
        tick(6);
        rst = 1'b0;
        tick(3);
        coin_sense = 1'b0;
        tick(8);

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check_eq("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
